sub_bytes_unit: RTL and testbench

Parametrised, handshaked AES SubBytes engine operating on a NUM_BYTES-wide state, substituting LANES bytes per cycle through the forward or inverse S-box. The mode is selected per transaction. It replaces the single-word combinational substitution in the round datapath. It sits between AddRoundKey and ShiftRows, with valid/ready on both sides so the round controller can stall it.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/sbox_lane.sv | 18 +
 rtl/sub_bytes_unit.sv | 149 ++++++++++++++
 tb/tb_sub_bytes_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the SubBytes engine:
//   byte_t       - one state byte
//   sbu_state_t  - control FSM states of sub_bytes_unit
//   FWD_SBOX     - forward S-box (encrypt), indexed by input byte
//   INV_SBOX     - inverse S-box (decrypt), indexed by input byte
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbu_state_t;

  localparam byte_t FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// ---------------------------------------------------------------------------
// sbox_lane
// One combinational S-box lookup.
//   byte_in  - byte to substitute
//   inv      - 0 selects the forward table, 1 the inverse table
//   byte_out - substituted byte
// ---------------------------------------------------------------------------
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

  assign byte_out = inv ? INV_SBOX[byte_in] : FWD_SBOX[byte_in];

endmodule

// File: rtl/sub_bytes_unit.sv
// ---------------------------------------------------------------------------
// sub_bytes_unit
// Handshaked AES SubBytes engine. A whole NUM_BYTES state is accepted in
// one cycle, then substituted LANES bytes per cycle over K = NUM_BYTES/LANES
// cycles, and presented as one registered result.
//   clk, rst   - clock, asynchronous active-high reset
//   in_valid   - upstream offers a state
//   in_ready   - unit accepts a state this cycle
//   in_data    - input state, byte i = in_data[8*i +: 8]
//   in_inv     - 0 forward S-box, 1 inverse S-box (latched at accept)
//   out_valid  - result available
//   out_ready  - downstream takes the result
//   out_data   - substituted state, byte i = S(byte i) or S^-1(byte i)
// ---------------------------------------------------------------------------
module sub_bytes_unit
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data
);

  localparam int K     = (LANES > 0) ? (NUM_BYTES / LANES) : 1;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int W     = 8 * NUM_BYTES;

  if (NUM_BYTES < 1 || LANES < 1 || LANES > NUM_BYTES || (NUM_BYTES % LANES) != 0) begin : g_bad_params
    $error("sub_bytes_unit: LANES must divide NUM_BYTES and lie in 1..NUM_BYTES");
  end

  sbu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     data_q, data_d;
  logic [W-1:0]     res_q, res_d;
  logic             inv_q, inv_d;
  logic             out_valid_q, out_valid_d;

  byte_t lane_in  [LANES];
  byte_t lane_out [LANES];

  // Route the current chunk of the latched state to the lanes. The chunk is
  // chosen by comparing the counter against each constant chunk number so
  // that every slice of data_q has a fixed position.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = '0;
    end
    for (int c = 0; c < K; c++) begin
      if (cnt_q == CNT_W'(c)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_in[l] = data_q[8*(c*LANES+l) +: 8];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .byte_in  (lane_in[l]),
      .inv      (inv_q),
      .byte_out (lane_out[l])
    );
  end

  // Next-state logic. A new state is captured from IDLE, or straight out of
  // DONE when the old result drains in the same cycle, so back-to-back
  // transactions see no extra bubble. BUSY writes the lane outputs in place
  // into the result register chunk by chunk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    res_d   = res_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int c = 0; c < K; c++) begin
          if (cnt_q == CNT_W'(c)) begin
            for (int l = 0; l < LANES; l++) begin
              res_d[8*(c*LANES+l) +: 8] = lane_out[l];
            end
          end
        end
        if (cnt_q == CNT_W'(K-1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  // State registers. Reset aborts any transaction in flight and clears the
  // visible result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      res_q       <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      res_q       <= res_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = res_q;

endmodule

// File: tb/tb_sub_bytes_unit.sv
// ---------------------------------------------------------------------------
// tb_sub_bytes_unit
// Drives a 16-byte/4-lane unit and a 1-byte/1-lane unit. Expected results
// come from an S-box built from GF(2^8) inversion plus the AES affine map.
// ---------------------------------------------------------------------------
module tb_sub_bytes_unit;

  localparam int NB = 16;
  localparam int LN = 4;
  localparam int K  = NB / LN;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [8*NB-1:0] in_data, out_data;

  logic          in_valid1, in_ready1, in_inv1, out_valid1, out_ready1;
  logic [7:0]    in_data1, out_data1;

  int checks = 0;
  int errors = 0;

  logic [7:0] refFwd [256];
  logic [7:0] refInv [256];
  logic [7:0] dutFwd [256];

  always #5 clk = ~clk;

  sub_bytes_unit #(.NUM_BYTES(NB), .LANES(LN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  sub_bytes_unit #(.NUM_BYTES(1), .LANES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_inv(in_inv1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine transform
  function automatic logic [7:0] sboxMath(input logic [7:0] b);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (b != 8'h00 && gfMul(b, 8'(y)) == 8'h01) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [8*NB-1:0] refSub(input logic [8*NB-1:0] d, input logic inv);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = inv ? refInv[d[8*i +: 8]] : refFwd[d[8*i +: 8]];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one transaction to the wide unit (called at a negedge), wait for
  // the result and optionally drain it. scramble keeps in_valid high and
  // changes in_data/in_inv every cycle while the unit works.
  task automatic applyStimulus(input logic [8*NB-1:0] data, input logic inv, input bit scramble,
                               input bit drain, output logic [8*NB-1:0] res, output int lat);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    in_inv   = inv;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    res = '0;
    lat = 0;
    if (!in_ready) begin
      checkOutput("accept timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid) break;
      if (scramble) begin
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_inv   = ~in_inv;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      checkOutput("result timeout", 128'd0, 128'd1);
      return;
    end
    res = out_data;
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8*NB-1:0] res, expB, dB, vin, vout;
    int lat, n;

    for (int x = 0; x < 256; x++) refFwd[x] = sboxMath(8'(x));
    for (int x = 0; x < 256; x++) refInv[refFwd[x]] = 8'(x);

    vin  = 128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19;
    vout = 128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; in_inv1 = 1'b0; out_ready1 = 1'b1;
    #3;
    checkOutput("reset out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset out_data", out_data, 128'd0);
    checkOutput("reset in_ready", 128'(in_ready), 128'd1);
    checkOutput("reset dut1 out_valid", 128'(out_valid1), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors
    applyStimulus(vin, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("kat fwd", res, vout);
    checkOutput("kat fwd latency", 128'(lat), 128'(K + 1));
    applyStimulus(vout, 1'b1, 1'b0, 1'b1, res, lat);
    checkOutput("kat inv", res, vin);
    applyStimulus('0, 1'b1, 1'b0, 1'b1, res, lat);
    checkOutput("zero inv", res, {NB{8'h52}});
    applyStimulus('0, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("zero fwd", res, {NB{8'h63}});
    checkOutput("model kat", refSub(vin, 1'b0), vout);

    // Random transactions, odd ones with inputs scrambled during BUSY
    for (int i = 0; i < 20; i++) begin
      logic [8*NB-1:0] d;
      logic m;
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      applyStimulus(d, m, bit'(i % 2), 1'b1, res, lat);
      checkOutput(i % 2 ? "rand scrambled" : "rand", res, refSub(d, m));
      checkOutput("rand latency", 128'(lat), 128'(K + 1));
    end

    // Backpressure: hold the result, then drain and accept together
    dB = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(vin, 1'b0, 1'b0, 1'b0, res, lat);
    checkOutput("bp result", res, vout);
    in_valid = 1'b1;
    in_data  = dB;
    in_inv   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp out_valid", 128'(out_valid), 128'd1);
      checkOutput("bp out_data", out_data, vout);
      checkOutput("bp in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp drain in_ready", 128'(in_ready), 128'd1);
    expB = refSub(dB, 1'b1);
    applyStimulus(dB, 1'b1, 1'b0, 1'b1, res, lat);
    checkOutput("bp next result", res, expB);
    checkOutput("bp next latency", 128'(lat), 128'(K + 1));

    // Reset in the middle of BUSY (chunk 2 pending)
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre-reset busy", 128'(in_ready), 128'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort out_data", out_data, 128'd0);
    checkOutput("abort in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 1'b1, res, lat);
    checkOutput("post-reset result", res, {NB{8'h63}});
    checkOutput("post-reset latency", 128'(lat), 128'(K + 1));

    // Exhaustive sweep on the single-lane unit: forward then inverse
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 256; x++) begin
        checkOutput("dut1 in_ready", 128'(in_ready1), 128'd1);
        in_valid1 = 1'b1;
        in_data1  = (m == 1) ? refFwd[x] : 8'(x);
        in_inv1   = 1'(m);
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 1;
        n = 0;
        while (!out_valid1 && n < 20) begin
          @(posedge clk);
          @(negedge clk);
          lat++;
          n++;
        end
        if (m == 0) begin
          dutFwd[x] = out_data1;
          checkOutput("sweep fwd", 128'(out_data1), 128'(refFwd[x]));
        end else begin
          checkOutput("sweep inv", 128'(out_data1), 128'(refInv[refFwd[x]]));
        end
        checkOutput("sweep latency", 128'(lat), 128'd2);
        @(posedge clk);
        @(negedge clk);
      end
    end
    checkOutput("fwd 00", 128'(dutFwd[0]), 128'h63);
    checkOutput("fwd 53", 128'(dutFwd[8'h53]), 128'hed);
    checkOutput("fwd ff", 128'(dutFwd[8'hff]), 128'h16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
